glift_seq_mult: RTL and testbench
=================================

GLIFT_SEQ_MULT -- requirements
Module: glift_seq_mult

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand width in bits (WIDTH >= 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to begin one multiplication.
REQ-005 SHALL have port: a  input  WIDTH  multiplicand value.
REQ-006 SHALL have port: a_t  input  WIDTH  per-bit taint label of a (1 = tainted).
REQ-007 SHALL have port: b  input  WIDTH  multiplier value.
REQ-008 SHALL have port: b_t  input  WIDTH  per-bit taint label of b.
REQ-009 SHALL have port: busy  output  1  high while rows are being accumulated.
REQ-010 SHALL have port: done  output  1  one-cycle pulse when p/p_t are updated.
REQ-011 SHALL have port: p  output  2*WIDTH  unsigned product a*b.
REQ-012 SHALL have port: p_t  output  2*WIDTH  per-bit taint label of p.
REQ-013 SHALL have port: any_t  output  1  OR-reduction of p_t.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE; all outputs registered.
REQ-015 In IDLE, start=1 at a rising edge SHALL capture a, a_t, b, b_t, clear accumulator value/taint and row counter k, and enter BUSY.
REQ-016 In BUSY, each edge SHALL add row k (pp[j] = a[j] AND b[k], shifted left by k, zero-filled untainted elsewhere) into the 2*WIDTH accumulator, then increment k.
REQ-017 Row taint SHALL use the exact GLIFT AND rule: pp_t[j] = (a_t[j] & b_t[k]) | (a[j] & ~a_t[j] & b_t[k]) | (b[k] & ~b_t[k] & a_t[j]).
REQ-018 Accumulator add SHALL be a 2*WIDTH ripple add with carry-in 0; final carry-out discarded (product cannot overflow).
REQ-019 Sum-bit taint SHALL be the exact XOR rule: x_t | y_t | c_t.
REQ-020 Carry-bit taint SHALL be the exact majority rule: 0 if any two of (x, y, c) are untainted and equal in value, else x_t | y_t | c_t.
REQ-021 After row WIDTH-1 the FSM SHALL enter DONE, loading p/p_t from the final accumulator; any_t = |p_t is loaded on the same edge.
REQ-022 DONE SHALL last exactly one cycle (done=1, busy=0), then return to IDLE unconditionally.
REQ-023 Latency: start sampled at edge E -> busy=1 after edges E .. E+WIDTH-1; done=1 and new p valid after edge E+WIDTH; done low after edge E+WIDTH+1.
REQ-024 start SHALL be ignored in BUSY and DONE (no restart, no operand recapture).
REQ-025 a, a_t, b, b_t SHALL be sampled only at the accepting edge; later input changes SHALL NOT affect the result.
REQ-026 p, p_t, any_t SHALL hold their last values in IDLE and BUSY, changing only on entry to DONE or reset.
REQ-027 start held high continuously SHALL produce back-to-back operations, one accepted per WIDTH+2 cycles.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, busy=0, done=0, p=0, p_t=0, any_t=0, k=0, accumulator value/taint=0, in any state, including mid-BUSY and DONE.
REQ-029 rst SHALL take priority over start on the same edge; the operation SHALL NOT be accepted.

Verification (WIDTH=4)
REQ-030 a=3, b=5, a_t=b_t=0, start 1 cycle -> busy 4 cycles, done pulse 1 cycle, p=15, p_t=0x00, any_t=0.
REQ-031 a=15, b=15, untainted -> p=225 (0xE1), p_t=0x00; second start during BUSY ignored, exactly one done pulse.
REQ-032 a=0, a_t=0x0, b=9, b_t=0xF -> p=0, p_t=0x00, any_t=0 (untainted zero masks taint).
REQ-033 a=1, a_t=0x0, b=1, b_t=0x1 -> p=1, p_t=0x01, any_t=1 (untainted carry not tainted).
REQ-034 a=5, a_t=0xF, b=3, b_t=0x0 -> p=15; p_t matches bit-accurate golden model of REQ-017..020; any_t=1.
REQ-035 start, rst asserted on 2nd BUSY cycle -> next cycle busy=0, done=0, p=0, p_t=0; new start a=2,b=7 -> p=14 after WIDTH+1 cycles.

Source files
------------

// File: rtl/glift_seq_mult.sv
// glift_seq_mult -- sequential shift-and-add unsigned multiplier with exact
// gate-level information flow tracking (GLIFT) of per-bit taint labels.
//
// One partial-product row is accumulated per clock while busy. Every row bit
// and every adder sum/carry bit carries a taint label. The label is computed
// with the exact (precise) GLIFT rule for that gate, so an untainted
// controlling value masks taint on the other input.
//
// Ports
//   clk    in   1        clock, all state changes on the rising edge
//   rst    in   1        synchronous active-high reset
//   start  in   1        begin one multiplication (accepted in IDLE only)
//   a      in   WIDTH    multiplicand
//   a_t    in   WIDTH    taint label per bit of a
//   b      in   WIDTH    multiplier
//   b_t    in   WIDTH    taint label per bit of b
//   busy   out  1        rows are being accumulated
//   done   out  1        one-cycle pulse, p/p_t/any_t just updated
//   p      out  2*WIDTH  unsigned product
//   p_t    out  2*WIDTH  taint label per bit of p
//   any_t  out  1        OR of all p_t bits
//
// state | meaning
// IDLE  | waiting for start, outputs hold the last result
// BUSY  | adding row k of the partial products into the accumulator
// DONE  | result published for one cycle, then back to IDLE

module glift_seq_mult #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     a_t,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     b_t,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p,
  output logic [2*WIDTH-1:0]   p_t,
  output logic                 any_t
);

  localparam int PW = 2 * WIDTH;
  localparam int KW = $clog2(WIDTH);
  localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, a_t_q, b_q, b_t_q;
  logic [PW-1:0]    acc_q, acc_t_q;
  logic [KW-1:0]    k_q;
  logic [PW-1:0]    p_q, p_t_q;
  logic             any_t_q;
  logic             busy_q, done_q;

  // current multiplier bit and its label
  logic             b_bit, b_bit_t;
  logic [WIDTH-1:0] pp_v, pp_t;
  logic [PW-1:0]    row_v, row_t;
  logic [PW-1:0]    acc_d, acc_t_d;

  assign b_bit   = b_q[k_q];
  assign b_bit_t = b_t_q[k_q];

  // Row k: AND of each a bit with b[k]. An untainted 0 on either input forces
  // the product bit to a known 0, so only then is the label cleared.
  always_comb begin
    pp_v = a_q & {WIDTH{b_bit}};
    pp_t = (a_t_q & {WIDTH{b_bit_t}})
         | (a_q & ~a_t_q & {WIDTH{b_bit_t}})
         | ({WIDTH{b_bit & ~b_bit_t}} & a_t_q);
  end

  // Bits outside the shifted row are constant untainted zeros.
  assign row_v = {{WIDTH{1'b0}}, pp_v} << k_q;
  assign row_t = {{WIDTH{1'b0}}, pp_t} << k_q;

  // Ripple add of accumulator and row with per-bit label propagation.
  always_comb begin : ripple_add
    logic x, y, c, xt, yt, ct;
    logic c_nxt, ct_nxt, masked;
    acc_d   = '0;
    acc_t_d = '0;
    c       = 1'b0;
    ct      = 1'b0;
    x       = 1'b0;
    y       = 1'b0;
    xt      = 1'b0;
    yt      = 1'b0;
    c_nxt   = 1'b0;
    ct_nxt  = 1'b0;
    masked  = 1'b0;
    for (int i = 0; i < PW; i++) begin
      x  = acc_q[i];
      xt = acc_t_q[i];
      y  = row_v[i];
      yt = row_t[i];
      acc_d[i]   = x ^ y ^ c;
      acc_t_d[i] = xt | yt | ct;
      // Majority output is fixed whenever two untainted inputs agree.
      masked = (~xt & ~yt & (x == y))
             | (~xt & ~ct & (x == c))
             | (~yt & ~ct & (y == c));
      c_nxt  = (x & y) | (x & c) | (y & c);
      ct_nxt = masked ? 1'b0 : (xt | yt | ct);
      c  = c_nxt;
      ct = ct_nxt;
    end
    // carry out of the top bit cannot be set: product fits in PW bits
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      a_t_q   <= '0;
      b_q     <= '0;
      b_t_q   <= '0;
      acc_q   <= '0;
      acc_t_q <= '0;
      k_q     <= '0;
      p_q     <= '0;
      p_t_q   <= '0;
      any_t_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            a_t_q   <= a_t;
            b_q     <= b;
            b_t_q   <= b_t;
            acc_q   <= '0;
            acc_t_q <= '0;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          acc_q   <= acc_d;
          acc_t_q <= acc_t_d;
          k_q     <= k_q + KW'(1);
          if (k_q == K_LAST) begin
            // publish the sum including the last row directly
            p_q     <= acc_d;
            p_t_q   <= acc_t_d;
            any_t_q <= |acc_t_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign p     = p_q;
  assign p_t   = p_t_q;
  assign any_t = any_t_q;

endmodule

// File: tb/tb_glift_seq_mult.sv
module tb_glift_seq_mult;

  localparam int W  = 4;
  localparam int PW = 2 * W;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  a_in, a_t_in, b_in, b_t_in;
  logic          busy, done;
  logic [PW-1:0] p, p_t;
  logic          any_t;

  int total = 0;
  int bad   = 0;

  logic [PW-1:0] exp_p, exp_pt;

  glift_seq_mult #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a_in),
    .a_t   (a_t_in),
    .b     (b_in),
    .b_t   (b_t_in),
    .busy  (busy),
    .done  (done),
    .p     (p),
    .p_t   (p_t),
    .any_t (any_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: shift-and-add over rows using the gate taint rules stated as
  // "is the gate output forced by untainted inputs?".
  function automatic logic [PW-1:0] gold_taint(input logic [W-1:0] av, at, bv, bt);
    int accv[PW];
    int acct[PW];
    int rv[PW];
    int rt[PW];
    int c, ct, s, un0, un1;
    logic [PW-1:0] res;
    for (int i = 0; i < PW; i++) begin accv[i] = 0; acct[i] = 0; end
    for (int k = 0; k < W; k++) begin
      for (int i = 0; i < PW; i++) begin
        rv[i] = 0;
        rt[i] = 0;
        if (i >= k && i - k < W) begin
          rv[i] = int'(av[i-k] & bv[k]);
          // AND: an untainted 0 on either side fixes the output
          if ((!at[i-k] && !av[i-k]) || (!bt[k] && !bv[k])) rt[i] = 0;
          else rt[i] = int'(at[i-k] | bt[k]);
        end
      end
      c = 0;
      ct = 0;
      for (int i = 0; i < PW; i++) begin
        s = accv[i] + rv[i] + c;
        un0 = 0;
        un1 = 0;
        if (acct[i] == 0) begin if (accv[i] == 0) un0++; else un1++; end
        if (rt[i] == 0)   begin if (rv[i] == 0)   un0++; else un1++; end
        if (ct == 0)      begin if (c == 0)       un0++; else un1++; end
        accv[i] = s % 2;
        acct[i] = (acct[i] | rt[i] | ct);
        c = s / 2;
        ct = (un0 >= 2 || un1 >= 2) ? 0 : 1 - ((un0 + un1 == 3) ? 1 : 0);
        if (un0 < 2 && un1 < 2) ct = (un0 + un1 == 3) ? 0 : 1;
      end
    end
    for (int i = 0; i < PW; i++) res[i] = (acct[i] != 0);
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] av, at, bv, bt, input bit extra_start);
    logic [PW-1:0] want_p, want_pt;
    want_p  = PW'(av) * PW'(bv);
    want_pt = gold_taint(av, at, bv, bt);
    a_in = av; a_t_in = at; b_in = bv; b_t_in = bt;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_accept", 16'(busy), 16'd1);
    chk("done_accept", 16'(done), 16'd0);
    a_in = W'($urandom); a_t_in = W'($urandom); b_in = W'($urandom); b_t_in = W'($urandom);
    for (int i = 1; i < W; i++) begin
      if (extra_start && i == 1) start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_run", 16'(busy), 16'd1);
      chk("done_run", 16'(done), 16'd0);
      chk("p_hold_busy", 16'(p), 16'(exp_p));
      chk("pt_hold_busy", 16'(p_t), 16'(exp_pt));
    end
    tick();
    chk("done_pulse", 16'(done), 16'd1);
    chk("busy_done", 16'(busy), 16'd0);
    chk("p", 16'(p), 16'(want_p));
    chk("p_t", 16'(p_t), 16'(want_pt));
    chk("any_t", 16'(any_t), 16'(|want_pt));
    exp_p  = want_p;
    exp_pt = want_pt;
    tick();
    chk("done_low", 16'(done), 16'd0);
    chk("busy_idle", 16'(busy), 16'd0);
    chk("p_hold_idle", 16'(p), 16'(exp_p));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    a_in = '0; a_t_in = '0; b_in = '0; b_t_in = '0;
    exp_p = '0; exp_pt = '0;
    tick();
    tick();
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_p", 16'(p), 16'd0);
    chk("rst_pt", 16'(p_t), 16'd0);
    chk("rst_any", 16'(any_t), 16'd0);
    rst = 1'b0;
    tick();

    // basic and masking cases
    run_op(4'd3, 4'h0, 4'd5, 4'h0, 1'b0);
    chk("p_3x5", 16'(p), 16'd15);
    run_op(4'd15, 4'h0, 4'd15, 4'h0, 1'b1);
    chk("p_15x15", 16'(p), 16'hE1);
    tick();
    chk("single_done", 16'(done), 16'd0);
    chk("no_restart", 16'(busy), 16'd0);
    run_op(4'd0, 4'h0, 4'd9, 4'hF, 1'b0);
    chk("zero_mask_pt", 16'(p_t), 16'h00);
    run_op(4'd1, 4'h0, 4'd1, 4'h1, 1'b0);
    chk("one_tainted_pt", 16'(p_t), 16'h01);
    run_op(4'd5, 4'hF, 4'd3, 4'h0, 1'b0);
    chk("a_tainted_pt", 16'(p_t), 16'h3F);

    // reset during the second busy cycle wins over start
    a_in = 4'd6; b_in = 4'd6; a_t_in = 4'h0; b_t_in = 4'h0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("b2_busy", 16'(busy), 16'd1);
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("midrst_busy", 16'(busy), 16'd0);
    chk("midrst_done", 16'(done), 16'd0);
    chk("midrst_p", 16'(p), 16'd0);
    chk("midrst_pt", 16'(p_t), 16'd0);
    chk("midrst_any", 16'(any_t), 16'd0);
    exp_p = '0; exp_pt = '0;
    tick();
    chk("midrst_stay_idle", 16'(busy), 16'd0);
    run_op(4'd2, 4'h0, 4'd7, 4'h0, 1'b0);
    chk("p_2x7", 16'(p), 16'd14);

    // reset in IDLE together with start: not accepted
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("rst_prio_busy", 16'(busy), 16'd0);
    tick();
    chk("rst_prio_idle", 16'(busy), 16'd0);
    chk("rst_prio_done", 16'(done), 16'd0);
    exp_p = '0; exp_pt = '0;

    // start held high: one accept every W+2 cycles
    begin
      logic [W-1:0] a1, b1, a2, b2;
      logic [PW-1:0] pt1, pt2;
      bit eb, ed;
      a1 = 4'd11; b1 = 4'd13; a2 = 4'd7; b2 = 4'd9;
      pt1 = gold_taint(a1, 4'h3, b1, 4'h0);
      pt2 = gold_taint(a2, 4'h0, b2, 4'h8);
      a_in = a1; a_t_in = 4'h3; b_in = b1; b_t_in = 4'h0;
      start = 1'b1;
      for (int o = 0; o <= 2 * W + 3; o++) begin
        tick();
        if (o == 0) begin a_in = a2; a_t_in = 4'h0; b_in = b2; b_t_in = 4'h8; end
        eb = (o < W) || (o >= W + 2 && o < 2 * W + 2);
        ed = (o == W) || (o == 2 * W + 2);
        chk("b2b_busy", 16'(busy), 16'(eb));
        chk("b2b_done", 16'(done), 16'(ed));
        if (o == W) begin
          chk("b2b_p1", 16'(p), 16'(PW'(a1) * PW'(b1)));
          chk("b2b_pt1", 16'(p_t), 16'(pt1));
        end
        if (o == W + 2) start = 1'b0;
        if (o == 2 * W + 2) begin
          chk("b2b_p2", 16'(p), 16'(PW'(a2) * PW'(b2)));
          chk("b2b_pt2", 16'(p_t), 16'(pt2));
          chk("b2b_any2", 16'(any_t), 16'(|pt2));
          exp_p = PW'(a2) * PW'(b2);
          exp_pt = pt2;
        end
      end
    end

    // random operands and labels
    for (int n = 0; n < 24; n++) begin
      run_op(W'($urandom), W'($urandom), W'($urandom), W'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
